// File: rtl/gray_codec_pipe.sv
// Two-stage valid/ready Gray codec: per-beat binary->Gray or Gray->binary conversion.
// Optional Gray adjacency checker enabled by defining GRAY_CODEC_STEP_CHK_EN.
module gray_codec_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic             o_mode,
    output logic [WIDTH-1:0] o_data,
    output logic             o_err
);

    // Stage 1: raw beat plus the adjacency verdict taken at acceptance time
    logic             s1_vld_reg;
    logic             s1_mode_reg;
    logic             s1_err_reg;
    logic [WIDTH-1:0] s1_data_reg;

    // Stage 2: converted beat driving the outputs
    logic             o_vld_reg;
    logic             o_mode_reg;
    logic             o_err_reg;
    logic [WIDTH-1:0] o_data_reg;

    logic             s1_rdy;
    logic             s2_rdy;
    logic             acc;
    logic             err_next;
    logic [WIDTH-1:0] b2g_next;
    logic [WIDTH-1:0] g2b_next;
    logic [WIDTH-1:0] conv_next;

    assign s2_rdy = !o_vld_reg || i_rdy;
    assign s1_rdy = !s1_vld_reg || s2_rdy;
    assign acc    = i_vld && s1_rdy;

    assign o_rdy  = s1_rdy;
    assign o_vld  = o_vld_reg;
    assign o_mode = o_mode_reg;
    assign o_data = o_data_reg;
    assign o_err  = o_err_reg;

    // Each decoded bit is the XOR of all Gray bits at or above it, written
    // as a reduction so there is no bit-to-bit chain inside one vector.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_conv
            if (gi == WIDTH - 1) begin : g_msb
                assign b2g_next[gi] = s1_data_reg[gi];
                assign g2b_next[gi] = s1_data_reg[gi];
            end else begin : g_low
                assign b2g_next[gi] = s1_data_reg[gi] ^ s1_data_reg[gi+1];
                assign g2b_next[gi] = ^s1_data_reg[WIDTH-1:gi];
            end
        end
    endgenerate

    assign conv_next = s1_mode_reg ? g2b_next : b2g_next;

`ifdef GRAY_CODEC_STEP_CHK_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             ref_vld_reg;
    logic [WIDTH-1:0] ref_data_reg;
    logic [WIDTH-1:0] step_diff;
    logic             step_one;
    logic             chk_hit;

    assign chk_hit   = acc && i_mode;
    assign step_diff = ref_data_reg ^ i_data;
    assign step_one  = (step_diff != '0) && ((step_diff & (step_diff - ONE)) == '0);
    // A clear in the acceptance cycle means this beat has no reference.
    assign err_next  = chk_hit && ref_vld_reg && !i_clr && !step_one;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ref_vld_reg  <= 1'b0;
            ref_data_reg <= '0;
        end else if (chk_hit) begin
            ref_vld_reg  <= 1'b1;
            ref_data_reg <= i_data;
        end else if (i_clr) begin
            ref_vld_reg  <= 1'b0;
        end
    end
`else
    logic unused_clr;

    assign unused_clr = i_clr;
    assign err_next   = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vld_reg  <= 1'b0;
            s1_mode_reg <= 1'b0;
            s1_err_reg  <= 1'b0;
            s1_data_reg <= '0;
        end else if (s1_rdy) begin
            s1_vld_reg <= i_vld;
            if (acc) begin
                s1_mode_reg <= i_mode;
                s1_err_reg  <= err_next;
                s1_data_reg <= i_data;
            end
        end
    end

    // Output registers only move when the downstream side can take a beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vld_reg  <= 1'b0;
            o_mode_reg <= 1'b0;
            o_err_reg  <= 1'b0;
            o_data_reg <= '0;
        end else if (s2_rdy) begin
            o_vld_reg <= s1_vld_reg;
            if (s1_vld_reg) begin
                o_mode_reg <= s1_mode_reg;
                o_err_reg  <= s1_err_reg;
                o_data_reg <= conv_next;
            end
        end
    end

endmodule

// File: doc/gray_codec_pipe.md
# gray_codec_pipe

Parametrised, two-stage pipelined Gray-code codec with per-beat mode selection (binary→Gray or Gray→binary) and a valid/ready handshake on both sides. It is the successor to the fixed-width, always-flowing binary→Gray register: it adds reverse conversion, backpressure, and an optional Gray adjacency checker. It sits between counter/pointer producers and consumers that need encoded or decoded values, such as FIFO pointer paths and position-encoder front ends.

## Interface
Parameters:
- WIDTH, 8, data width in bits (≥2).

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_clr  in  1  synchronous clear of the adjacency-checker reference; pipeline data unaffected.
- i_vld  in  1  upstream beat valid.
- o_rdy  out  1  upstream ready; a beat is accepted when i_vld && o_rdy.
- i_mode  in  1  0 = binary→Gray, 1 = Gray→binary; sampled with the beat.
- i_data  in  WIDTH  input word.
- o_vld  out  1  output beat valid.
- i_rdy  in  1  downstream ready; a beat is consumed when o_vld && i_rdy.
- o_mode  out  1  mode of the current output beat.
- o_data  out  WIDTH  converted word.
- o_err  out  1  adjacency error flag for the current output beat (0 when the checker is compiled out).

## Operation
- Stage 1 (S1) registers i_data, i_mode, and valid.
- Stage 2 (S2) registers the conversion of the S1 contents into o_data/o_mode/o_err/o_vld.
- Binary→Gray: g[WIDTH-1]=b[WIDTH-1]; g[i]=b[i]^b[i+1].
- Gray→binary: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i] (full prefix XOR, computed between S1 and S2).
- Backpressure:
  - s2_rdy = !o_vld || i_rdy.
  - s1_rdy = !s1_vld || s2_rdy.
  - o_rdy = s1_rdy, combinational from registered state and i_rdy only; no dependency on i_vld.
- A stalled stage holds its contents unchanged. Beats are never dropped, duplicated, or reordered.
- Simultaneous accept and consume on a full pipeline: both stages advance in the same cycle and throughput stays at 1 beat/cycle.
- Mode is per beat. Mixed-mode streams are legal, and each beat is converted per its own i_mode.

## Timing
- Reset (async assert, sync-safe deassert): S1/S2 valid=0, o_data=0, o_mode=0, o_err=0, checker reference invalid. o_rdy=1 in the first cycle after reset.
- Latency: a beat accepted at edge N appears on o_vld/o_data after edge N+1 when unstalled, i.e. 2 register stages.
- Throughput: 1 beat/cycle with i_rdy held high.
- o_data, o_mode, and o_err are stable while o_vld=1 and i_rdy=0.
- Reset asserted mid-stream discards all in-flight beats immediately.
- i_clr takes effect at the next edge. A beat accepted in the same cycle as i_clr is checked against no reference (o_err=0) and becomes the new reference.

## Configuration
- Macro GRAY_CODEC_STEP_CHK_EN.
- Defined:
  - Each accepted Gray→binary beat (i_mode=1) is compared with the previous accepted Gray→binary input.
  - o_err=1 on that beat's output when the Hamming distance ≠ 1; distance 0 is an error.
  - The first Gray→binary beat after reset or i_clr has no reference, so o_err=0.
  - Binary→Gray beats neither update the reference nor raise o_err.
  - The reference updates on acceptance, not on output consumption.
- Undefined: no reference register and no comparator; o_err is tied to 0; i_clr is ignored.

## Test plan
- WIDTH=4, i_mode=0, i_data=4'b0110, i_rdy=1 → o_vld two edges after acceptance, o_data=4'b0101, o_mode=0, o_err=0.
- i_mode=1, i_data=4'b0101 → o_data=4'b0110. Sweep all 16 codes in both modes; round-trip equals the original value.
- Stream 8 beats with i_rdy low for cycles 3–6 → o_rdy drops once both stages are full; all 8 beats emerge in order with no loss or duplication; o_data is held stable while stalled.
- With GRAY_CODEC_STEP_CHK_EN, Gray inputs 0101, 0100, 0100, 0111:
  - o_err = 0, 0, 1, 1.
  - Then i_clr followed by 0000 → o_err=0.
- Interleave modes as Gray 0001, bin 1111, Gray 0011 → o_err=0 on all three (the binary beat is skipped by the checker); 0001→0011 is adjacent.
- Assert i_rst_n low asynchronously with 2 beats in flight → o_vld=0 and o_data=0 immediately; after release o_rdy=1 and the first new beat carries o_err=0.
